// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell (two half adders + OR) reused over WIDTH cycles.
// Optional subtract support is enabled by defining SERIAL_ADDER_SUB_EN.

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_load;
    logic             cin_load;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load   = sub ? ~b : b;
    assign cin_load = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = b;
    assign cin_load   = 1'b0;
`endif

    logic s1, c1, s_bit, c2, c_out;

    half_adder u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]), .s_o(s1),    .c_o(c1));
    half_adder u_ha1 (.a_i(s1),     .b_i(c_q),    .s_o(s_bit), .c_o(c2));
    assign c_out = c1 | c2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_load;
                    cnt_d   = '0;
                    c_d     = cin_load;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB so the first (LSB) result ends at bit 0.
                sum_d = {s_bit, sum_q[WIDTH-1:1]};
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                c_d   = c_out;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    carry_d = c_out;
                    ovf_d   = c_q ^ c_out;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule
